// File: rtl/exu_result_arbiter.sv
// Writeback arbiter: per-channel result FIFOs drained round-robin onto
// WB_PORT registered writeback ports. Results and packets are carried as
// flat vectors of width DATA_W / PKT_W.
module exu_result_arbiter #(
  parameter int UNIT_NUM   = 4,
  parameter int WB_PORT    = 2,
  parameter int FIFO_DEPTH = 2,
  parameter int DATA_W     = 32,
  parameter int PKT_W      = 16
) (
  input  logic                               clk_i,
  input  logic                               rst_n_i,
  input  logic                               flush_i,
  input  logic                               stall_i,
  input  logic [UNIT_NUM-1:0]                unit_valid_i,
  input  logic [UNIT_NUM-1:0][DATA_W-1:0]    unit_result_i,
  input  logic [UNIT_NUM-1:0][PKT_W-1:0]     unit_ipacket_i,
  output logic [UNIT_NUM-1:0]                unit_ready_o,
  output logic [WB_PORT-1:0][DATA_W-1:0]     result_o,
  output logic [WB_PORT-1:0][PKT_W-1:0]      ipacket_o,
  output logic [WB_PORT-1:0]                 data_valid_o,
  output logic                               overflow_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int RR_W  = $clog2(UNIT_NUM);
  localparam int ENT_W = DATA_W + PKT_W;

  logic [ENT_W-1:0]                 mem [UNIT_NUM][FIFO_DEPTH];
  logic [UNIT_NUM-1:0][PTR_W-1:0]   wptr;
  logic [UNIT_NUM-1:0][PTR_W-1:0]   rptr;
  logic [UNIT_NUM-1:0][CNT_W-1:0]   cnt;
  logic [RR_W-1:0]                  rr;
  logic [RR_W-1:0]                  rr_nxt;
  logic [UNIT_NUM-1:0]              push;
  logic [UNIT_NUM-1:0]              pop;
  logic [WB_PORT-1:0]               gnt_vld;
  logic [WB_PORT-1:0][RR_W-1:0]     gnt_ch;

  // Ready and push qualification, decoded from registered counts only
  always_comb begin
    for (int c = 0; c < UNIT_NUM; c++) begin
      unit_ready_o[c] = (cnt[c] != CNT_W'(FIFO_DEPTH));
      push[c]         = unit_valid_i[c] & unit_ready_o[c] & ~flush_i;
    end
  end

  // Round-robin scan from rr; the n-th non-empty channel found goes to port n
  always_comb begin
    logic [RR_W-1:0] idx;
    int              n;
    idx     = '0;
    n       = 0;
    pop     = '0;
    gnt_vld = '0;
    gnt_ch  = '0;
    rr_nxt  = rr;
    if (!stall_i && !flush_i) begin
      for (int k = 0; k < UNIT_NUM; k++) begin
        idx = RR_W'((int'(rr) + k) % UNIT_NUM);
        if (cnt[idx] != '0 && n < WB_PORT) begin
          pop[idx] = 1'b1;
          for (int p = 0; p < WB_PORT; p++) begin
            if (p == n) begin
              gnt_vld[p] = 1'b1;
              gnt_ch[p]  = idx;
            end
          end
          rr_nxt = RR_W'((int'(idx) + 1) % UNIT_NUM);
          n      = n + 1;
        end
      end
    end
  end

  // FIFO storage; contents need no reset since count gates visibility
  always_ff @(posedge clk_i) begin
    for (int c = 0; c < UNIT_NUM; c++) begin
      if (push[c]) mem[c][wptr[c]] <= {unit_result_i[c], unit_ipacket_i[c]};
    end
  end

  // FIFO pointers and counts; flush empties everything
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else if (flush_i) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      for (int c = 0; c < UNIT_NUM; c++) begin
        if (push[c]) wptr[c] <= wptr[c] + 1'b1;
        if (pop[c])  rptr[c] <= rptr[c] + 1'b1;
        case ({push[c], pop[c]})
          2'b10:   cnt[c] <= cnt[c] + 1'b1;
          2'b01:   cnt[c] <= cnt[c] - 1'b1;
          default: cnt[c] <= cnt[c];
        endcase
      end
    end
  end

  // Round-robin pointer follows the last granted channel
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)     rr <= '0;
    else if (flush_i) rr <= '0;
    else              rr <= rr_nxt;
  end

  // Registered writeback ports; ungranted ports are zeroed for OR-merging
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      data_valid_o <= '0;
      result_o     <= '0;
      ipacket_o    <= '0;
    end else if (flush_i) begin
      data_valid_o <= '0;
      result_o     <= '0;
      ipacket_o    <= '0;
    end else if (!stall_i) begin
      for (int p = 0; p < WB_PORT; p++) begin
        data_valid_o[p] <= gnt_vld[p];
        if (gnt_vld[p]) begin
          result_o[p]  <= mem[gnt_ch[p]][rptr[gnt_ch[p]]][ENT_W-1:PKT_W];
          ipacket_o[p] <= mem[gnt_ch[p]][rptr[gnt_ch[p]]][PKT_W-1:0];
        end else begin
          result_o[p]  <= '0;
          ipacket_o[p] <= '0;
        end
      end
    end
  end

  // Sticky overflow: any push attempt into a full FIFO
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)                                          overflow_o <= 1'b0;
    else if (!flush_i && |(unit_valid_i & ~unit_ready_o)) overflow_o <= 1'b1;
  end

endmodule

// File: tb/tb_exu_result_arbiter.sv
// Directed bench for exu_result_arbiter: default configuration on dut_a,
// FIFO_DEPTH=4 on dut_b for pointer wrap.
module tb_exu_result_arbiter;

  logic clk = 1'b0;
  logic rst_n;

  logic             a_flush, a_stall;
  logic [3:0]       a_valid;
  logic [3:0][31:0] a_res_in;
  logic [3:0][15:0] a_pkt_in;
  logic [3:0]       a_ready;
  logic [1:0][31:0] a_res;
  logic [1:0][15:0] a_pkt;
  logic [1:0]       a_dv;
  logic             a_ovf;

  logic             b_flush, b_stall;
  logic [3:0]       b_valid;
  logic [3:0][31:0] b_res_in;
  logic [3:0][15:0] b_pkt_in;
  logic [3:0]       b_ready;
  logic [1:0][31:0] b_res;
  logic [1:0][15:0] b_pkt;
  logic [1:0]       b_dv;
  logic             b_ovf;

  int n_chk  = 0;
  int n_fail = 0;

  exu_result_arbiter #(.UNIT_NUM(4), .WB_PORT(2), .FIFO_DEPTH(2)) dut_a (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(a_flush), .stall_i(a_stall),
    .unit_valid_i(a_valid), .unit_result_i(a_res_in), .unit_ipacket_i(a_pkt_in),
    .unit_ready_o(a_ready), .result_o(a_res), .ipacket_o(a_pkt),
    .data_valid_o(a_dv), .overflow_o(a_ovf));

  exu_result_arbiter #(.UNIT_NUM(4), .WB_PORT(2), .FIFO_DEPTH(4)) dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(b_flush), .stall_i(b_stall),
    .unit_valid_i(b_valid), .unit_result_i(b_res_in), .unit_ipacket_i(b_pkt_in),
    .unit_ready_o(b_ready), .result_o(b_res), .ipacket_o(b_pkt),
    .data_valid_o(b_dv), .overflow_o(b_ovf));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int push_n [4];
  int pop_n  [4];
  int first;

  initial begin
    rst_n = 1'b0;
    a_flush = 0; a_stall = 0; a_valid = '0; a_res_in = '0; a_pkt_in = '0;
    b_flush = 0; b_stall = 0; b_valid = '0; b_res_in = '0; b_pkt_in = '0;
    #1;
    chk("rst_ready", a_ready, 4'hF);
    chk("rst_dv", a_dv, 2'b00);
    chk("rst_ovf", a_ovf, 1'b0);
    tick(); tick();
    rst_n = 1'b1;
    chk("post_rst_ready", a_ready, 4'hF);

    // single push on ch2
    a_valid = 4'b0100; a_res_in[2] = 32'h1234; a_pkt_in[2] = 16'h0042;
    tick();
    chk("single_nobypass_dv", a_dv, 2'b00);
    a_valid = '0;
    tick();
    chk("single_dv", a_dv, 2'b01);
    chk("single_res0", a_res[0], 32'h1234);
    chk("single_pkt0", a_pkt[0], 16'h0042);
    chk("single_res1_zero", a_res[1], 32'h0);
    chk("single_rr", dut_a.rr, 2'd3);
    tick();
    chk("single_idle_dv", a_dv, 2'b00);
    chk("single_rr_hold", dut_a.rr, 2'd3);

    a_flush = 1; tick(); a_flush = 0;
    chk("flush_rr", dut_a.rr, 2'd0);

    // all channels push whenever ready
    for (int c = 0; c < 4; c++) begin push_n[c] = 0; pop_n[c] = 0; end
    for (int i = 0; i < 7; i++) begin
      for (int c = 0; c < 4; c++) begin
        a_valid[c]  = a_ready[c];
        a_res_in[c] = 32'(c * 256 + push_n[c]);
        a_pkt_in[c] = 16'(c);
        if (a_ready[c]) push_n[c]++;
      end
      tick();
      if (i == 0) begin
        chk("rr_first_dv", a_dv, 2'b00);
      end else begin
        first = (i % 2 == 1) ? 0 : 2;
        chk("rr_dv", a_dv, 2'b11);
        chk("rr_port0", a_res[0], 64'(first * 256 + pop_n[first]));
        chk("rr_port1", a_res[1], 64'((first + 1) * 256 + pop_n[first + 1]));
        chk("rr_pkt1", a_pkt[1], 64'(first + 1));
        pop_n[first]++;
        pop_n[first + 1]++;
      end
    end
    a_valid = '0;
    chk("rr_no_ovf", a_ovf, 1'b0);
    a_flush = 1; tick(); a_flush = 0;
    chk("flush_dv", a_dv, 2'b00);

    // overflow under stall
    a_stall = 1;
    a_valid = 4'b0001; a_res_in[0] = 32'hA0;
    tick();
    chk("ovf_ready_after1", a_ready[0], 1'b1);
    a_res_in[0] = 32'hB0;
    tick();
    chk("ovf_ready_after2", a_ready[0], 1'b0);
    chk("ovf_not_yet", a_ovf, 1'b0);
    a_res_in[0] = 32'hC0;
    tick();
    chk("ovf_set", a_ovf, 1'b1);
    chk("ovf_stall_dv", a_dv, 2'b00);
    a_valid = '0; a_stall = 0;
    tick();
    chk("ovf_out1_dv", a_dv, 2'b01);
    chk("ovf_out1", a_res[0], 32'hA0);
    tick();
    chk("ovf_out2_dv", a_dv, 2'b01);
    chk("ovf_out2", a_res[0], 32'hB0);
    tick();
    chk("ovf_out3_dv", a_dv, 2'b00);
    chk("ovf_ready_back", a_ready, 4'hF);

    // flush beats stall and push
    a_valid = 4'b0010; a_res_in[1] = 32'h5A;
    tick();
    a_flush = 1; a_stall = 1; a_valid = 4'b1000; a_res_in[3] = 32'h3C;
    tick();
    chk("fl_cnt", dut_a.cnt, 8'h00);
    chk("fl_dv", a_dv, 2'b00);
    chk("fl_rr", dut_a.rr, 2'd0);
    chk("fl_ovf_kept", a_ovf, 1'b1);
    chk("fl_ready", a_ready, 4'hF);
    a_flush = 0; a_stall = 0; a_valid = '0;
    tick();
    chk("fl_after_dv", a_dv, 2'b00);

    // reset mid-stream
    a_valid = 4'b0001; a_res_in[0] = 32'h77;
    tick();
    a_valid = '0;
    tick();
    a_stall = 1;
    a_valid = 4'b0100; a_res_in[2] = 32'h55;
    tick();
    a_res_in[2] = 32'h66;
    tick();
    a_valid = '0;
    chk("mid_held_dv", a_dv, 2'b01);
    chk("mid_held_res", a_res[0], 32'h77);
    chk("mid_buffered", a_ready[2], 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_dv", a_dv, 2'b00);
    chk("mid_rst_res", a_res, 64'h0);
    chk("mid_rst_ready", a_ready, 4'hF);
    chk("mid_rst_ovf", a_ovf, 1'b0);
    a_stall = 0;
    #2 rst_n = 1'b1;
    tick();
    chk("mid_rel_dv1", a_dv, 2'b00);
    tick();
    chk("mid_rel_dv2", a_dv, 2'b00);
    a_valid = 4'b0010; a_res_in[1] = 32'h99;
    tick();
    a_valid = '0;
    tick();
    chk("mid_new_dv", a_dv, 2'b01);
    chk("mid_new_res", a_res[0], 32'h99);

    // pointer wrap on depth-4 instance
    for (int i = 0; i < 9; i++) begin
      b_valid     = (i < 6) ? 4'b0010 : 4'b0000;
      b_res_in[1] = 32'(32'h10 + i);
      b_stall     = (i < 3);
      tick();
      if (i >= 3) begin
        chk("wrap_dv", b_dv, 2'b01);
        chk("wrap_data", b_res[0], 64'(32'h10 + i - 3));
      end else begin
        chk("wrap_stall_dv", b_dv, 2'b00);
      end
    end
    b_valid = '0;
    chk("wrap_wptr", dut_b.wptr[1], 2'd2);
    chk("wrap_rptr", dut_b.rptr[1], 2'd2);
    chk("wrap_ovf", b_ovf, 1'b0);
    tick();
    chk("wrap_empty_dv", b_dv, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/exu_result_arbiter.md
EXU_RESULT_ARBITER -- requirements
Module: exu_result_arbiter

Interface
REQ-001 SHALL have parameter UNIT_NUM, default 4: number of functional-unit result channels, range 2..8.
REQ-002 SHALL have parameter WB_PORT, default 2: number of writeback ports, range 1..UNIT_NUM.
REQ-003 SHALL have parameter FIFO_DEPTH, default 2: entries per channel FIFO, power of two, at least 2.
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n_i, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port flush_i, input, 1 bit: discards all buffered and output results.
REQ-007 SHALL have port stall_i, input, 1 bit: freezes the output registers and all pops.
REQ-008 SHALL have port unit_valid_i, input, [UNIT_NUM]: push request per channel.
REQ-009 SHALL have port unit_result_i, input, [UNIT_NUM] x data_word_t: result per channel.
REQ-010 SHALL have port unit_ipacket_i, input, [UNIT_NUM] x instr_packet_t: packet per channel.
REQ-011 SHALL have port unit_ready_o, output, [UNIT_NUM]: channel FIFO not full.
REQ-012 SHALL have port result_o, output, [WB_PORT] x data_word_t: writeback data.
REQ-013 SHALL have port ipacket_o, output, [WB_PORT] x instr_packet_t: writeback packet.
REQ-014 SHALL have port data_valid_o, output, [WB_PORT]: writeback valid.
REQ-015 SHALL have port overflow_o, output, 1 bit: sticky flag, set by a push into a full FIFO.

Function
REQ-016 SHALL give each channel its own FIFO_DEPTH circular FIFO with read/write pointers and a count register (0..FIFO_DEPTH).
REQ-017 SHALL push {unit_result_i, unit_ipacket_i} when unit_valid_i[c] and unit_ready_o[c] are both high and flush_i is low.
REQ-018 SHALL drive unit_ready_o[c] = (count[c] != FIFO_DEPTH), decoded from registered state only.
REQ-019 SHALL drop a push with unit_valid_i[c] high and unit_ready_o[c] low, and set overflow_o until reset.
REQ-020 SHALL wrap FIFO pointers modulo FIFO_DEPTH.
REQ-021 SHALL keep count unchanged on a simultaneous push and pop to the same channel.
REQ-022 SHALL keep a round-robin pointer rr (0..UNIT_NUM-1); each non-stalled cycle, scan channels rr, rr+1, ... modulo UNIT_NUM and grant up to WB_PORT non-empty channels.
REQ-023 SHALL assign granted channels to writeback ports in scan order: first grant to port 0, second to port 1, and so on.
REQ-024 SHALL pop each granted FIFO head and register it into its port, setting data_valid_o for that port.
REQ-025 SHALL clear data_valid_o on ungranted ports and drive their result_o and ipacket_o to all zeros, so outputs can be OR-merged.
REQ-026 SHALL advance rr to (last granted channel + 1) modulo UNIT_NUM; rr holds when nothing is granted.
REQ-027 SHALL have a latency of one cycle through the FIFO: a push at edge k appears on the outputs after edge k+1 when granted and not stalled; there is no bypass path.
REQ-028 SHALL, while stall_i is high and flush_i is low, hold the outputs, rr, and FIFO heads, and grant nothing; pushes still proceed.
REQ-029 SHALL, on flush_i, at the next edge empty every FIFO (count 0, pointers 0), clear data_valid_o, zero result_o and ipacket_o, and reset rr to 0; overflow_o is kept.
REQ-030 SHALL give flush_i priority over stall_i and over any simultaneous push or pop.
REQ-031 SHALL never grant one channel to two ports in the same cycle.

Reset
REQ-032 SHALL, on rst_n_i low, asynchronously clear FIFO counts, pointers, rr, data_valid_o, result_o, ipacket_o and overflow_o.
REQ-033 SHALL drive unit_ready_o all ones during and after reset.
REQ-034 SHALL discard in-flight entries on reset mid-operation; the first pushes after reset release are accepted normally.

Verification
REQ-035 SHALL pass: single push on ch2 (result 0x1234) at edge 0 -> data_valid_o[0]=1 with result 0x1234 after edge 1; rr becomes 3.
REQ-036 SHALL pass: all 4 channels push every cycle, WB_PORT=2 -> grants alternate {0,1},{2,3},{0,1}; no channel starves; throughput 2 per cycle.
REQ-037 SHALL pass: ch0 pushes 3 times with stall_i high -> unit_ready_o[0]=0 after 2 pushes, 3rd push dropped, overflow_o=1; after stall release, exactly 2 results out in order.
REQ-038 SHALL pass: flush_i together with a push and stall_i -> next cycle all counts 0, data_valid_o=0, rr=0, overflow_o unchanged.
REQ-039 SHALL pass: rst_n_i asserted mid-stream with 2 entries buffered -> outputs zero immediately, unit_ready_o all ones, nothing emitted after release.
REQ-040 SHALL pass: with FIFO_DEPTH=4 and 6 pushes/pops alternating on one channel -> pointers wrap and data order is preserved.
